// File: rtl/loa_share_pkg.sv
// Shared definitions for the LOA shared-adder arbiter slice.
//   id_w()      : requester-index width for R requesters (at least 1 bit)
//   MODE_*      : accuracy-mode encodings carried with each request
//   loa_req_t   : packed request record at the default configuration
//                 (N=16, R=4); parameterised modules declare a local record
//                 with the same field order.
package loa_share_pkg;

  function automatic int unsigned id_w(input int unsigned r);
    return (r <= 1) ? 1 : $clog2(r);
  endfunction

  localparam logic MODE_EXACT = 1'b0;
  localparam logic MODE_LOA   = 1'b1;

  localparam int unsigned DEF_N = 16;
  localparam int unsigned DEF_R = 4;

  typedef struct packed {
    logic [DEF_N-1:0]         x;
    logic [DEF_N-1:0]         y;
    logic                     approx;
    logic [$clog2(DEF_R)-1:0] id;
  } loa_req_t;

endpackage

// File: rtl/loa_share_arbiter_datapath.sv
// Combinational lower-part-OR adder (LOA) alongside the exact adder.
//   x, y      : N-bit operands
//   sum_loa   : {hi, lo}, lo = OR of the low P bits, hi = upper add with
//               carry-in from the AND of the top low-part bits
//   sum_exact : x + y, N+1 bits
//   mismatch  : sum_loa differs from sum_exact
module loa_datapath #(
  parameter int unsigned N = 16,
  parameter int unsigned P = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N:0]   sum_loa,
  output logic [N:0]   sum_exact,
  output logic         mismatch
);

  logic [P-1:0] lo;
  logic         c;
  logic [N-P:0] hi;

  assign lo        = x[P-1:0] | y[P-1:0];
  assign c         = x[P-1] & y[P-1];
  assign hi        = {1'b0, x[N-1:P]} + {1'b0, y[N-1:P]} + (N-P+1)'(c);
  assign sum_loa   = {hi, lo};
  assign sum_exact = {1'b0, x} + {1'b0, y};
  assign mismatch  = (sum_loa != sum_exact);

endmodule

// File: rtl/loa_share_arbiter.sv
// Round-robin arbiter feeding a 2-stage pipeline around one shared LOA/exact
// adder. Responses return on a single valid/ready channel tagged with the
// requester id; approximate responses that differ from the exact sum are
// counted in a saturating error counter.
//   clk, rst_n         : clock, asynchronous active-low reset
//   req_valid/ready    : per-requester handshake (ready is the one-hot grant)
//   req_x, req_y       : packed operands, requester i owns [i*N +: N]
//   req_approx         : 1 = LOA sum, 0 = exact sum
//   rsp_valid/ready    : response handshake
//   rsp_sum/id/approx  : response payload
//   err_cnt, clr_err   : saturating mismatch count and its synchronous clear
module loa_share_arbiter
  import loa_share_pkg::*;
#(
  parameter int unsigned N  = 16,
  parameter int unsigned P  = 8,
  parameter int unsigned R  = 4,
  parameter int unsigned EW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [R-1:0]         req_valid,
  input  logic [R*N-1:0]       req_x,
  input  logic [R*N-1:0]       req_y,
  input  logic [R-1:0]         req_approx,
  output logic [R-1:0]         req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [N:0]           rsp_sum,
  output logic [id_w(R)-1:0]   rsp_id,
  output logic                 rsp_approx,
  output logic [EW-1:0]        err_cnt,
  input  logic                 clr_err
);

  localparam int unsigned ID_W = id_w(R);

  typedef struct packed {
    logic [N-1:0]    x;
    logic [N-1:0]    y;
    logic            approx;
    logic [ID_W-1:0] id;
  } s1_req_t;

  logic            adv;
  logic            ld1;
  logic            s1_valid;
  s1_req_t         s1;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gnt;
  logic            found;
  logic            acc;
  int unsigned     idx;

  logic [N:0]      sum_loa;
  logic [N:0]      sum_exact;
  logic            mismatch;
  logic            rsp_mis;

  assign adv = !rsp_valid || rsp_ready;
  assign ld1 = !s1_valid || adv;

  // Rotating priority search: first set request at or after rr_ptr.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < R; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= R) idx = idx - R;
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found = 1'b1;
        gnt   = idx[ID_W-1:0];
      end
    end
  end

  // Gated by rst_n so no grant is presented while held in reset.
  assign acc       = rst_n && ld1 && found;
  assign req_ready = acc ? (R'(1) << gnt) : '0;

  // Stage 1: request register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
      rr_ptr   <= '0;
    end else if (acc) begin
      s1_valid  <= 1'b1;
      s1.x      <= req_x[gnt*N +: N];
      s1.y      <= req_y[gnt*N +: N];
      s1.approx <= req_approx[gnt];
      s1.id     <= gnt;
      rr_ptr    <= (gnt == ID_W'(R-1)) ? '0 : gnt + ID_W'(1);
    end else if (adv) begin
      s1_valid <= 1'b0;
    end
  end

  loa_datapath #(
    .N(N),
    .P(P)
  ) u_dp (
    .x         (s1.x),
    .y         (s1.y),
    .sum_loa   (sum_loa),
    .sum_exact (sum_exact),
    .mismatch  (mismatch)
  );

  // Stage 2: output register; holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_sum    <= '0;
      rsp_id     <= '0;
      rsp_approx <= 1'b0;
      rsp_mis    <= 1'b0;
    end else if (adv) begin
      rsp_valid  <= s1_valid;
      rsp_sum    <= (s1.approx == MODE_EXACT) ? sum_exact : sum_loa;
      rsp_id     <= s1.id;
      rsp_approx <= s1.approx;
      rsp_mis    <= mismatch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr_err) begin
      err_cnt <= '0;
    end else if (rsp_valid && rsp_ready && (rsp_approx == MODE_LOA) &&
                 rsp_mis && (err_cnt != '1)) begin
      err_cnt <= err_cnt + EW'(1);
    end
  end

endmodule

// File: tb/tb_loa_share_arbiter.sv
module tb_loa_share_arbiter;
  import loa_share_pkg::*;

  localparam int unsigned N  = 16;
  localparam int unsigned P  = 8;
  localparam int unsigned R  = 4;
  localparam int unsigned EW = 16;
  localparam int unsigned IW = 2;

  logic           clk;
  logic           rst_n;
  logic [R-1:0]   req_valid;
  logic [R*N-1:0] req_x;
  logic [R*N-1:0] req_y;
  logic [R-1:0]   req_approx;
  logic           rsp_ready;
  logic           clr_err;

  logic [R-1:0]   req_ready,  req_ready2;
  logic           rsp_valid,  rsp_valid2;
  logic [N:0]     rsp_sum,    rsp_sum2;
  logic [IW-1:0]  rsp_id,     rsp_id2;
  logic           rsp_approx, rsp_approx2;
  logic [EW-1:0]  err_cnt;
  logic [1:0]     err_cnt2;

  int unsigned n_vec = 0;
  int unsigned n_mis = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  loa_share_arbiter #(.N(N), .P(P), .R(R), .EW(EW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x),
    .req_y(req_y), .req_approx(req_approx), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_id(rsp_id), .rsp_approx(rsp_approx), .err_cnt(err_cnt),
    .clr_err(clr_err)
  );

  loa_share_arbiter #(.N(N), .P(P), .R(R), .EW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x),
    .req_y(req_y), .req_approx(req_approx), .req_ready(req_ready2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum2),
    .rsp_id(rsp_id2), .rsp_approx(rsp_approx2), .err_cnt(err_cnt2),
    .clr_err(clr_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference sums straight from the arithmetic definition.
  function automatic logic [N:0] model_sum(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic ap);
    int unsigned xi, yi, lo, hi, c;
    xi = 32'(x);
    yi = 32'(y);
    if (!ap) return (N+1)'(xi + yi);
    lo = (xi | yi) % (32'd1 << P);
    c  = ((xi >> (P-1)) & (yi >> (P-1))) & 32'd1;
    hi = (xi >> P) + (yi >> P) + c;
    return (N+1)'(hi * (32'd1 << P) + lo);
  endfunction

  // Model: the two pipeline slots as a queue of at most two entries; the
  // head becomes visible on the response port one cycle after acceptance.
  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         ap;
    int unsigned  id;
    bit           vis;
  } ent_t;

  ent_t        q[$];
  int unsigned m_ptr;
  int unsigned m_err;
  int unsigned m_err2;

  initial begin
    ent_t        e;
    ent_t        h;
    bit          vis, dep, adv, space;
    int          win;
    int unsigned j;
    logic [R-1:0] exp_rdy;
    logic [N:0]   es;
    m_ptr = 0; m_err = 0; m_err2 = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        m_ptr = 0; m_err = 0; m_err2 = 0;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_rsp_valid_sat", 32'(rsp_valid2), 32'd0);
      end else begin
        vis = (q.size() > 0) && q[0].vis;
        chk("rsp_valid", 32'(rsp_valid), 32'(vis));
        chk("rsp_valid_sat", 32'(rsp_valid2), 32'(vis));
        if (vis) begin
          h  = q[0];
          es = model_sum(h.x, h.y, h.ap);
          chk("rsp_sum", 32'(rsp_sum), 32'(es));
          chk("rsp_id", 32'(rsp_id), h.id);
          chk("rsp_approx", 32'(rsp_approx), 32'(h.ap));
          chk("rsp_sum_sat", 32'(rsp_sum2), 32'(es));
          chk("rsp_id_sat", 32'(rsp_id2), h.id);
          chk("rsp_approx_sat", 32'(rsp_approx2), 32'(h.ap));
        end
        chk("err_cnt", 32'(err_cnt), m_err);
        chk("err_cnt_sat", 32'(err_cnt2), m_err2);

        dep   = vis && rsp_ready;
        space = (q.size() - (dep ? 1 : 0)) < 2;
        win   = -1;
        for (int unsigned k = 0; k < R; k++) begin
          j = (m_ptr + k) % R;
          if (win < 0 && req_valid[j]) win = int'(j);
        end
        exp_rdy = (space && win >= 0) ? (R'(1) << win) : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("req_ready_sat", 32'(req_ready2), 32'(exp_rdy));

        // Advance the model to the state after the coming rising edge.
        if (dep) begin
          h = q.pop_front();
          if (h.ap && model_sum(h.x, h.y, 1'b1) != model_sum(h.x, h.y, 1'b0)) begin
            if (m_err < 65535) m_err++;
            if (m_err2 < 3) m_err2++;
          end
        end
        if (clr_err) begin
          m_err = 0; m_err2 = 0;
        end
        adv = !vis || rsp_ready;
        if (adv && q.size() > 0 && !q[0].vis) begin
          e = q[0]; e.vis = 1'b1; q[0] = e;
        end
        if (space && win >= 0) begin
          e.x   = req_x[win*N +: N];
          e.y   = req_y[win*N +: N];
          e.ap  = req_approx[win];
          e.id  = win;
          e.vis = 1'b0;
          q.push_back(e);
          m_ptr = (int'(win) + 1) % R;
        end
      end
    end
  end

  task automatic new_req(input int unsigned i);
    req_x[i*N +: N]  = N'($urandom);
    req_y[i*N +: N]  = N'($urandom);
    req_approx[i]    = 1'($urandom_range(0, 1));
    req_valid[i]     = 1'b1;
  endtask

  // One isolated request with literal expectations; rsp_ready held high.
  task automatic do_single(input int unsigned id, input logic [N-1:0] x, input logic [N-1:0] y,
                           input logic ap, input logic [N:0] exp_sum,
                           input int unsigned exp_err, input int unsigned exp_err2,
                           input bit clr);
    int unsigned n;
    bit          got;
    @(posedge clk); #1;
    rsp_ready       = 1'b1;
    req_x[id*N +: N] = x;
    req_y[id*N +: N] = y;
    req_approx[id]  = ap;
    req_valid[id]   = 1'b1;
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      got = req_ready[id];
      n++;
    end
    chk("single_accept", 32'(got), 32'd1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    @(negedge clk);
    chk("single_latency_lo", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    clr_err = clr;
    @(negedge clk);
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_sum", 32'(rsp_sum), 32'(exp_sum));
    chk("single_id", 32'(rsp_id), id);
    @(posedge clk); #1;
    clr_err = 1'b0;
    @(negedge clk);
    chk("single_err", 32'(err_cnt), exp_err);
    chk("single_err_sat", 32'(err_cnt2), exp_err2);
  endtask

  initial begin
    logic [R-1:0] acc;
    rst_n = 1'b0; req_valid = '0; req_x = '0; req_y = '0; req_approx = '0;
    rsp_ready = 1'b0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Literal cases
    do_single(2, 16'h00FF, 16'h0001, 1'b1, 17'h000FF, 1, 1, 1'b0);
    do_single(1, 16'h0180, 16'h0080, 1'b1, 17'h00280, 2, 2, 1'b0);
    do_single(0, 16'h0180, 16'h0080, 1'b0, 17'h00200, 2, 2, 1'b0);
    do_single(2, 16'h1234, 16'h0001, 1'b1, 17'h01235, 2, 2, 1'b0);
    do_single(3, 16'hFFFF, 16'h0001, 1'b0, 17'h10000, 2, 2, 1'b0);

    // Fairness: all requesting, pointer starts at 0 after requester 3.
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    for (int unsigned i = 0; i < R; i++) new_req(i);
    for (int unsigned k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("fair_grant", 32'(req_ready), 32'd1 << (k % 4));
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      for (int unsigned i = 0; i < R; i++) if (acc[i]) new_req(i);
    end
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: two slots fill, then no grant.
    rsp_ready = 1'b0;
    for (int unsigned i = 0; i < R; i++) new_req(i);
    for (int unsigned k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_grant", 32'(req_ready != '0), 32'(k < 2));
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      for (int unsigned i = 0; i < R; i++) if (acc[i]) new_req(i);
    end
    rsp_ready = 1'b1;
    for (int unsigned k = 0; k < 6; k++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      for (int unsigned i = 0; i < R; i++) if (acc[i]) new_req(i);
    end
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;

    // Randomised traffic
    acc = '0;
    for (int unsigned c = 0; c < 1500; c++) begin
      for (int unsigned i = 0; i < R; i++) begin
        if (acc[i] || !req_valid[i]) begin
          if ($urandom_range(0, 3) != 0) new_req(i);
          else req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      clr_err   = ($urandom_range(0, 63) == 0);
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
    end
    clr_err = 1'b0;

    // Reset with both stages full
    rsp_ready = 1'b0;
    for (int unsigned i = 0; i < R; i++) if (acc[i] || !req_valid[i]) new_req(i);
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      for (int unsigned i = 0; i < R; i++) if (acc[i]) new_req(i);
    end
    chk("pre_reset_full", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_rsp_valid_now", 32'(rsp_valid), 32'd0);
    chk("reset_req_ready_now", 32'(req_ready), 32'd0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (5) @(posedge clk);

    // Saturation of the 2-bit counter, then clear beating an increment.
    for (int unsigned k = 0; k < 4; k++)
      do_single(0, 16'h00FF, 16'h0001, 1'b1, 17'h000FF, k + 1, (k + 1 > 3) ? 3 : k + 1, 1'b0);
    do_single(1, 16'h00FF, 16'h0001, 1'b1, 17'h000FF, 0, 0, 1'b1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/loa_share_arbiter.md
Name: loa_share_arbiter

Overview:
- Round-robin arbiter and 2-stage pipeline controller sharing one lower-part-OR approximate adder datapath among R requesters.
- Each request carries an accuracy-mode bit: approximate (LOA) or exact sum.
- Results return on one valid/ready response channel, tagged with the requester id.
- A saturating counter records approximate responses whose value differs from the exact sum; the quality-monitoring logic reads it.

Parameters:
- N, 16, operand width.
- P, 8, width of the OR-approximated lower part; 1 <= P < N.
- R, 4, number of requesters; R >= 2.
- EW, 16, error-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  R  per-requester request valid.
- req_x  in  R*N  operand X; requester i owns bits [i*N +: N].
- req_y  in  R*N  operand Y; same packing as req_x.
- req_approx  in  R  1 = LOA sum, 0 = exact sum.
- req_ready  out  R  one-hot grant/accept.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_sum  out  N+1  sum including carry-out.
- rsp_id  out  clog2(R)  granted requester index.
- rsp_approx  out  1  mode used for this response.
- err_cnt  out  EW  saturating mismatch count.
- clr_err  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset (async, rst_n=0): clear s1_valid, rsp_valid, err_cnt and the round-robin pointer (rr_ptr=0). rsp_sum, rsp_id and rsp_approx reset to 0. req_ready is 0 while rst_n=0.
- Pipeline advance: adv = !rsp_valid || rsp_ready.
- Stage-1 load enable: ld1 = !s1_valid || adv.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, ascending with wrap-around; the first set bit wins.
  - req_ready[g] = ld1 && req_valid[g] for the winner only; all other bits are 0.
- Accept: req_valid[g] && req_ready[g]. On accept, stage 1 registers x, y, approx and id, sets s1_valid, and sets rr_ptr = (g+1) mod R.
- With no accept, rr_ptr holds and s1_valid clears if adv is high. No accept occurs while ld1=0.
- Requester rule: req_valid, and that requester's operands and mode, stay stable until accepted. req_valid never depends on req_ready.
- Stage 2: when adv is high, the output register loads from stage 1:
  - rsp_valid <= s1_valid.
  - rsp_sum = LOA(x,y) if approx=1, else x+y (N+1 bits).
  - rsp_id and rsp_approx are copied from stage 1.
- Hold rule: while rsp_valid && !rsp_ready, all response outputs hold stable.
- Latency: accept at edge t gives rsp_valid at edge t+1 when unstalled. Throughput is 1 response per cycle.
- LOA arithmetic:
  - lo = x[P-1:0] | y[P-1:0].
  - c = x[P-1] & y[P-1].
  - hi = x[N-1:P] + y[N-1:P] + c, width N-P+1.
  - sum = {hi, lo}.
- Error count: on the response handshake (rsp_valid && rsp_ready && rsp_approx), increment err_cnt by 1 if rsp_sum differs from the exact sum of the same operands. Stage 2 keeps a registered mismatch flag for this.
  - err_cnt saturates at 2^EW-1.
  - clr_err forces err_cnt to 0 and overrides a same-cycle increment.
- Simultaneous events: a new accept and a stage-2 drain in the same cycle are legal, giving full throughput. Non-winning requesters keep req_ready=0.
- Reset mid-operation: in-flight requests are dropped with no response, and rr_ptr returns to 0.

Decomposition:
- Package loa_share_pkg:
  - ID_W = clog2(R) function.
  - mode constants MODE_EXACT=0 and MODE_LOA=1.
  - a packed request struct {x, y, approx, id}.
- Sub-module loa_datapath (N, P):
  - Combinational.
  - Outputs sum_loa and sum_exact (both N+1 bits) and mismatch = (sum_loa != sum_exact).
  - Instantiated once, at stage 2.

Test Plan:
1. Single LOA request, N=16, P=8, requester 2: x=0x00FF, y=0x0001, approx=1 -> rsp_sum=0x000FF, rsp_id=2, rsp_valid one cycle after accept; after handshake err_cnt=1.
2. LOA carry path: x=0x0180, y=0x0080, approx=1 -> rsp_sum=0x00280. Same operands with approx=0 -> 0x00200. err_cnt increments only for the approx response.
3. No mismatch: x=0x1234, y=0x0001, approx=1 -> rsp_sum=0x01235, err_cnt unchanged. Then x=0xFFFF, y=0x0001, approx=0 -> 0x10000.
4. Fairness: all 4 req_valid held high with rsp_ready=1 -> grant order 0,1,2,3,0,...; one response per cycle; rsp_id sequence matches the grant order.
5. Backpressure: rsp_ready=0 for 5 cycles with continuous requests -> stage 1 and the output register fill, then req_ready=0. The held response stays stable. On release, responses drain in order with no loss or duplication.
6. Reset and saturation:
   - Assert rst_n=0 with both stages full -> rsp_valid=0 immediately and no stale response after release.
   - With EW=2, four mismatching approx responses -> err_cnt=3 (saturated).
   - clr_err together with a mismatching handshake -> err_cnt=0.
